cpu_program_loader: RTL and testbench
=====================================

// Module: cpu_program_loader
// PURPOSE
//  Host-side driver for the 8-bit accumulator CPU's serial program-load port. A host fills a 32x8
//  program buffer. On start, the block streams the buffer into the CPU over Load/data_in, one byte per clock.
//  It then releases the CPU to run, watches the CPU Instruction bus for HLT (opcode 3'b000), and reports
//  completion, the halt PC and the elapsed cycles. A timeout guards against programs that never halt.
// PARAMETERS
//  DEPTH        32    program buffer words; equals CPU PC range (2**ADDR_W)
//  ADDR_W       5     buffer/PC address width
//  DATA_W       8     instruction width
//  RUN_GUARD    2     RUN cycles ignored before HLT detection (CPU fetch latency)
//  TIMEOUT      1024  max RUN cycles before abort
// PORTS
//  clock        in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  prog_we      in   1       host buffer write strobe
//  prog_waddr   in   ADDR_W  host buffer write address
//  prog_wdata   in   DATA_W  host buffer write data
//  prog_len     in   ADDR_W+1  words to load, valid 1..DEPTH; sampled on start
//  start        in   1       1-cycle request; ignored unless IDLE or DONE
//  cpu_load     out  1       drives CPU Load
//  cpu_data     out  DATA_W  drives CPU data_in
//  cpu_instr    in   DATA_W  CPU Instruction output {opcode[7:5], addr[4:0]}
//  cpu_pc       in   ADDR_W  CPU Program_counter output
//  busy         out  1       high in LOAD or RUN
//  done         out  1       level; set entering DONE, cleared by start or reset
//  timed_out    out  1       valid with done: RUN hit TIMEOUT without HLT
//  len_err      out  1       valid with done: prog_len was 0 or > DEPTH, nothing loaded
//  halt_pc      out  ADDR_W  cpu_pc captured on HLT detection
//  run_cycles   out  16      RUN cycles elapsed; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE; cpu_load=0, cpu_data=0, busy=0, done=0, timed_out=0, len_err=0, halt_pc=0,
//   run_cycles=0. Buffer contents are not cleared.
//  Buffer: synchronous write when prog_we && !busy. Writes while busy are dropped. Reads are registered.
//  FSM states: IDLE, LOAD, RUN, DONE.
//   IDLE/DONE + start:
//    - prog_len in 1..DEPTH: latch len. Clear done, flags and run_cycles. Go to LOAD with idx=0.
//    - otherwise: go to DONE with len_err=1. cpu_load stays 0.
//   LOAD: cpu_load=1. cpu_data=buf[k] in the k-th LOAD cycle (k=0..len-1), addresses in ascending order.
//    LOAD lasts exactly len cycles. The first byte appears in the cycle after start, so buffer read-ahead is required.
//    After the last byte: cpu_load=0, cpu_data=0, go to RUN.
//   RUN: cpu_load=0. run_cycles increments every cycle.
//    - HLT: cpu_instr[7:5]==3'b000 and run_cycles>=RUN_GUARD. Capture halt_pc=cpu_pc and go to DONE.
//    - Timeout: run_cycles==TIMEOUT-1 without HLT. Set timed_out=1 and go to DONE.
//    - If HLT and timeout occur in the same cycle, HLT wins and timed_out=0.
//   DONE: done=1, outputs held until the next start.
//  start during LOAD or RUN is ignored.
//  reset mid-LOAD or mid-RUN: cpu_load drops to 0 in the same edge; the CPU is reset separately by the host.
//  len==DEPTH loads addresses 0..31 with no wrap. Index arithmetic is ADDR_W+1 wide, so index 32 never aliases to 0.
//  Latency: start to first cpu_load=1 is 1 cycle; start to RUN entry is len+1 cycles.
// STRUCTURE
//  Shared package cpu_pkg:
//   - opcode localparams OP_HLT=3'b000, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
//   - ADDR_W=5, DATA_W=8
//   - loader state enum
//  Sub-module prog_buffer: 1W1R synchronous RAM, DEPTH x DATA_W. Instantiated once; FSM and counters stay in this file.
// TESTING
//  1. Reset then idle: all outputs 0. prog_we with addr=3, data=8'hA5 is stored, confirmed by a later load.
//  2. len=4, buf={8'hA1,8'h42,8'hC3,8'h00}, start -> cpu_load=1 for exactly 4 cycles, data A1,42,C3,00 in order.
//     Then cpu_load=0 and busy stays 1.
//  3. RUN with cpu_instr held at 8'h00 from RUN cycle 0: no halt before RUN_GUARD.
//     Halt at run_cycles=2 -> done=1, halt_pc=cpu_pc, timed_out=0.
//  4. RUN with cpu_instr=8'hE0 (JMP 0) forever -> done=1, timed_out=1 after exactly TIMEOUT RUN cycles.
//  5. prog_len=0, then prog_len=33 -> done=1, len_err=1, cpu_load never asserted.
//     len=32 loads all 32 words; byte 31 is the last byte.
//  6. reset asserted at LOAD cycle 2 -> next edge: IDLE, cpu_load=0. prog_we during LOAD is ignored.
//     start during RUN is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : shared constants, opcodes and loader state type for the 8-bit accumulator CPU
// Revision 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int RUN_W  = 16;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } loader_state_t;

   function automatic logic is_hlt(input logic [2:0] opcode);
      return opcode == OP_HLT;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_program_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_program_loader_if : host buffer/control bus plus CPU load and status lines
// Revision 1.0
// ---------------------------------------------------------------------------
interface cpu_program_loader_if;
   import cpu_pkg::*;

   logic              prog_we;
   logic [ADDR_W-1:0] prog_waddr;
   logic [DATA_W-1:0] prog_wdata;
   logic [ADDR_W:0]   prog_len;
   logic              start;
   logic              cpu_load;
   logic [DATA_W-1:0] cpu_data;
   logic [DATA_W-1:0] cpu_instr;
   logic [ADDR_W-1:0] cpu_pc;
   logic              busy;
   logic              done;
   logic              timed_out;
   logic              len_err;
   logic [ADDR_W-1:0] halt_pc;
   logic [RUN_W-1:0]  run_cycles;

   modport master (
      output prog_we, prog_waddr, prog_wdata, prog_len, start, cpu_instr, cpu_pc,
      input  cpu_load, cpu_data, busy, done, timed_out, len_err, halt_pc, run_cycles
   );

   modport slave (
      input  prog_we, prog_waddr, prog_wdata, prog_len, start, cpu_instr, cpu_pc,
      output cpu_load, cpu_data, busy, done, timed_out, len_err, halt_pc, run_cycles
   );

endinterface
`default_nettype wire

// File: rtl/prog_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prog_buffer : DEPTH x DATA_W one-write one-read RAM with registered read data
// Revision 1.0
// ---------------------------------------------------------------------------
module prog_buffer
   import cpu_pkg::*;
(
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      rdata <= r_mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/cpu_program_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_program_loader : streams the program buffer into the CPU, then times its run to HLT
// Revision 1.0
// ---------------------------------------------------------------------------
module cpu_program_loader
   import cpu_pkg::*;
#(
   parameter int RUN_GUARD = 2,
   parameter int TIMEOUT   = 1024
)(
   input logic                 clock,
   input logic                 reset,
   cpu_program_loader_if.slave bus
);

   localparam logic [RUN_W-1:0]  C_GUARD    = RUN_W'(RUN_GUARD);
   localparam logic [RUN_W-1:0]  C_TMO_LAST = RUN_W'(TIMEOUT - 1);
   localparam logic [RUN_W-1:0]  C_RUN_ONE  = RUN_W'(1);
   localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   C_IDX_ONE  = (ADDR_W+1)'(1);

   loader_state_t     r_state;
   loader_state_t     w_state_nxt;
   logic [ADDR_W:0]   r_idx;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   w_idx_inc;
   logic [ADDR_W-1:0] w_raddr;
   logic [DATA_W-1:0] w_rdata;
   logic              w_busy;
   logic              w_len_ok;
   logic              w_accept;
   logic              w_reject;
   logic              w_last;
   logic              w_hlt;
   logic              w_tmo;
   logic              r_timed_out;
   logic              r_len_err;
   logic [ADDR_W-1:0] r_halt_pc;
   logic [RUN_W-1:0]  r_run_cycles;

   assign w_busy    = (r_state == ST_LOAD) || (r_state == ST_RUN);
   assign w_idx_inc = r_idx + C_IDX_ONE;
   assign w_last    = (w_idx_inc == r_len);
   assign w_len_ok  = (bus.prog_len != '0) && (bus.prog_len <= C_DEPTH);
   assign w_hlt     = is_hlt(bus.cpu_instr[DATA_W-1 -: 3]) && (r_run_cycles >= C_GUARD);
   assign w_tmo     = (r_run_cycles == C_TMO_LAST);

   // Address 0 is pre-read while idle so byte 0 is ready the cycle after start;
   // during LOAD the RAM always fetches one word ahead of the byte being driven.
   assign w_raddr = (r_state == ST_LOAD) ? w_idx_inc[ADDR_W-1:0] : '0;

   prog_buffer u_prog_buffer (
      .clock (clock),
      .we    (bus.prog_we && !w_busy),
      .waddr (bus.prog_waddr),
      .wdata (bus.prog_wdata),
      .raddr (w_raddr),
      .rdata (w_rdata)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      bus.cpu_load = 1'b0;
      bus.cpu_data = '0;
      bus.busy     = w_busy;
      bus.done     = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            bus.done = (r_state == ST_DONE);
            if (bus.start) begin
               if (w_len_ok) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_reject    = 1'b1;
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_LOAD: begin
            bus.cpu_load = 1'b1;
            bus.cpu_data = w_rdata;
            if (w_last) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_hlt || w_tmo) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_idx        <= '0;
         r_len        <= '0;
         r_timed_out  <= 1'b0;
         r_len_err    <= 1'b0;
         r_halt_pc    <= '0;
         r_run_cycles <= '0;
      end else begin
         if (w_accept) begin
            r_len        <= bus.prog_len;
            r_idx        <= '0;
            r_timed_out  <= 1'b0;
            r_len_err    <= 1'b0;
            r_run_cycles <= '0;
         end
         if (w_reject) begin
            r_len_err   <= 1'b1;
            r_timed_out <= 1'b0;
         end
         if (r_state == ST_LOAD) begin
            r_idx <= w_idx_inc;
         end
         if (r_state == ST_RUN) begin
            if (r_run_cycles != '1) begin
               r_run_cycles <= r_run_cycles + C_RUN_ONE;
            end
            // A halt on the timeout cycle takes priority over the timeout.
            if (w_hlt) begin
               r_halt_pc <= bus.cpu_pc;
            end else if (w_tmo) begin
               r_timed_out <= 1'b1;
            end
         end
      end
   end

   assign bus.timed_out  = r_timed_out;
   assign bus.len_err    = r_len_err;
   assign bus.halt_pc    = r_halt_pc;
   assign bus.run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_cpu_program_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_program_loader : directed bench with a per-cycle expectation model of the loader
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cpu_program_loader;
   import cpu_pkg::*;

   localparam int RUN_GUARD = 2;
   localparam int TIMEOUT   = 1024;

   logic clock = 1'b0;
   logic reset = 1'b1;

   cpu_program_loader_if bus();

   cpu_program_loader #(
      .RUN_GUARD (RUN_GUARD),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int         n_pass  = 0;
   int         n_total = 0;
   logic [7:0] mem  [32];
   logic [7:0] seen [32];
   bit         chk_en = 1'b0;
   logic       exp_load;
   logic       exp_busy;
   logic       exp_done;
   logic [7:0] exp_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Cycle-by-cycle comparison of the load/handshake outputs against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("cpu_load", 32'(bus.cpu_load), 32'(exp_load));
         check("cpu_data", 32'(bus.cpu_data), 32'(exp_data));
         check("busy",     32'(bus.busy),     32'(exp_busy));
         check("done",     32'(bus.done),     32'(exp_done));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      bus.prog_we    = 1'b1;
      bus.prog_waddr = 5'(a);
      bus.prog_wdata = d;
      tick();
      bus.prog_we = 1'b0;
      mem[a]      = d;
   endtask

   task automatic run_prog(input int len, input int halt_from, input logic [7:0] hlt_op);
      int r;
      bit hit_h;
      bit hit_t;
      bus.prog_len = 6'(len);
      bus.start    = 1'b1;
      tick();
      for (int k = 0; k < len; k++) begin
         exp_load  = 1'b1;
         exp_data  = mem[k];
         exp_busy  = 1'b1;
         exp_done  = 1'b0;
         seen[k]   = bus.cpu_data;
         bus.start = (k == 1);
         tick();
      end
      bus.start = 1'b0;
      r     = 0;
      hit_h = 1'b0;
      hit_t = 1'b0;
      forever begin
         exp_load      = 1'b0;
         exp_data      = 8'h00;
         exp_busy      = 1'b1;
         exp_done      = 1'b0;
         bus.cpu_instr = (r >= halt_from) ? hlt_op : 8'hE0;
         bus.cpu_pc    = 5'(r + 3);
         bus.start     = (r == 0);
         hit_h         = (r >= halt_from) && (r >= RUN_GUARD);
         hit_t         = (r == TIMEOUT - 1);
         tick();
         r++;
         if (hit_h || hit_t) break;
      end
      bus.start     = 1'b0;
      bus.cpu_instr = 8'hE0;
      exp_busy      = 1'b0;
      exp_done      = 1'b1;
      check("run_cycles", 32'(bus.run_cycles), 32'(r));
      check("timed_out",  32'(bus.timed_out),  32'(!hit_h));
      check("len_err",    32'(bus.len_err),    32'd0);
      if (hit_h) check("halt_pc", 32'(bus.halt_pc), 32'((r - 1 + 3) % 32));
   endtask

   task automatic bad_start(input int len);
      bus.prog_len = 6'(len);
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      exp_load  = 1'b0;
      exp_data  = 8'h00;
      exp_busy  = 1'b0;
      exp_done  = 1'b1;
      check("len_err_set",  32'(bus.len_err),   32'd1);
      check("len_err_done", 32'(bus.done),      32'd1);
      check("len_err_tmo",  32'(bus.timed_out), 32'd0);
      tick();
   endtask

   initial begin
      bus.prog_we    = 1'b0;
      bus.prog_waddr = '0;
      bus.prog_wdata = '0;
      bus.prog_len   = '0;
      bus.start      = 1'b0;
      bus.cpu_instr  = 8'hE0;
      bus.cpu_pc     = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check("rst_cpu_load",   32'(bus.cpu_load),   32'd0);
      check("rst_cpu_data",   32'(bus.cpu_data),   32'd0);
      check("rst_busy",       32'(bus.busy),       32'd0);
      check("rst_done",       32'(bus.done),       32'd0);
      check("rst_timed_out",  32'(bus.timed_out),  32'd0);
      check("rst_len_err",    32'(bus.len_err),    32'd0);
      check("rst_halt_pc",    32'(bus.halt_pc),    32'd0);
      check("rst_run_cycles", 32'(bus.run_cycles), 32'd0);
      exp_load = 1'b0;
      exp_data = 8'h00;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      chk_en   = 1'b1;

      // Host write at address 3, confirmed through a load; halt late at RUN cycle 5.
      wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'hA5);
      run_prog(4, 5, 8'h00);
      check("t1_byte3",   32'(seen[3]),        32'h0000_00A5);
      check("t1_cycles",  32'(bus.run_cycles), 32'd6);
      check("t1_halt_pc", 32'(bus.halt_pc),    32'd8);

      // Four-byte program, HLT present from RUN cycle 0: guard delays halt to cycle 2.
      wr(0, 8'hA1); wr(1, 8'h42); wr(2, 8'hC3); wr(3, 8'h00);
      run_prog(4, 0, 8'h00);
      check("t2_byte0",   32'(seen[0]),        32'h0000_00A1);
      check("t2_byte1",   32'(seen[1]),        32'h0000_0042);
      check("t2_byte2",   32'(seen[2]),        32'h0000_00C3);
      check("t2_byte3",   32'(seen[3]),        32'h0000_0000);
      check("t3_cycles",  32'(bus.run_cycles), 32'd3);
      check("t3_halt_pc", 32'(bus.halt_pc),    32'd5);

      // JMP forever: timeout after exactly TIMEOUT RUN cycles.
      run_prog(4, 2000, 8'h00);
      check("t4_cycles",  32'(bus.run_cycles), 32'd1024);
      check("t4_timeout", 32'(bus.timed_out),  32'd1);

      // HLT (with nonzero address field) on the timeout cycle: HLT wins.
      run_prog(4, TIMEOUT - 1, 8'h1F);
      check("tb_cycles",  32'(bus.run_cycles), 32'd1024);
      check("tb_timeout", 32'(bus.timed_out),  32'd0);
      check("tb_halt_pc", 32'(bus.halt_pc),    32'd2);

      // Out-of-range lengths.
      bad_start(0);
      bad_start(33);

      // Full-depth load, no wrap.
      for (int i = 0; i < 32; i++) wr(i, 8'(i * 37 + 5));
      run_prog(32, 3, 8'h00);
      check("t5_byte0",  32'(seen[0]),        32'h0000_0005);
      check("t5_byte31", 32'(seen[31]),       32'h0000_0080);
      check("t5_cycles", 32'(bus.run_cycles), 32'd4);

      // Reset in LOAD cycle 2, with a host write attempted during LOAD.
      bus.prog_len = 6'd8;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_load = 1'b1;
         exp_data = mem[k];
         exp_busy = 1'b1;
         exp_done = 1'b0;
         if (k == 0) begin
            bus.prog_we    = 1'b1;
            bus.prog_waddr = 5'd1;
            bus.prog_wdata = 8'h77;
         end
         if (k == 2) reset = 1'b1;
         tick();
         bus.prog_we = 1'b0;
      end
      reset    = 1'b0;
      exp_load = 1'b0;
      exp_data = 8'h00;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      check("t6_cpu_load",   32'(bus.cpu_load),   32'd0);
      check("t6_busy",       32'(bus.busy),       32'd0);
      check("t6_run_cycles", 32'(bus.run_cycles), 32'd0);
      check("t6_halt_pc",    32'(bus.halt_pc),    32'd0);
      tick();

      run_prog(2, 2, 8'h00);
      check("t6_dropped_write", 32'(seen[1]), 32'h0000_002A);
      tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
